// File: rtl/sample_projective_pixel_pkg.sv
// Shared constants for the projective pixel sampler: tag layout carried
// alongside each coordinate through the read-latency pipeline.
package sample_projective_pixel_pkg;
  localparam int TAG_W  = 3;
  localparam int TAG_FS = 2;
  localparam int TAG_LE = 1;
  localparam int TAG_RO = 0;

  typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/sample_projective_pixel_fifo.sv
// First-word-fall-through synchronous FIFO with registered head/valid outputs.
// Overflow is prevented upstream by the credit counter, so writes are unchecked.
module sample_projective_pixel_fifo #(
  parameter int WIDTH = 26,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid
);
  localparam int DEPTH = 2**PTR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_vld;

  logic             w_pop;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [PTR_W:0]   w_cnt_nxt;
  logic [WIDTH-1:0] w_head;

  assign w_pop      = i_rd && r_vld;
  assign w_rptr_nxt = r_rptr + 1'b1;
  assign w_cnt_nxt  = r_cnt + (PTR_W+1)'(i_wr) - (PTR_W+1)'(w_pop);

  // Next head: the entry behind the current one, or the incoming word when
  // the FIFO is (or becomes) empty.
  always_comb begin
    w_head = r_dout;
    if (w_pop) begin
      if (r_cnt > (PTR_W+1)'(1)) w_head = r_mem[w_rptr_nxt];
      else if (i_wr)             w_head = i_wdata;
    end else if (r_cnt == '0 && i_wr) begin
      w_head = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      if (i_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= w_rptr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_vld  <= (w_cnt_nxt != '0);
      r_dout <= w_head;
    end
  end

  assign o_rdata = r_dout;
  assign o_valid = r_vld;
endmodule

// File: rtl/sample_projective_pixel.sv
// Consumes projective source coordinates, reads the frame buffer for in-range
// ones and emits an in-order pixel stream with background fill and flags.
module sample_projective_pixel
  import sample_projective_pixel_pkg::*;
#(
  parameter int SRC_X_WIDTH    = 10,
  parameter int SRC_Y_WIDTH    = 10,
  parameter int SRC_X_NUM      = 640,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 24,
  parameter int MEM_LATENCY    = 2,
  parameter int FIFO_PTR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_frame_start,
  input  logic                   s_line_end,
  input  logic                   s_range_out,
  input  logic [SRC_X_WIDTH-1:0] s_x,
  input  logic [SRC_Y_WIDTH-1:0] s_y,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   mem_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   m_frame_start,
  output logic                   m_line_end,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready
);
  localparam int DEPTH = 2**FIFO_PTR_WIDTH;
  localparam int CW    = FIFO_PTR_WIDTH + 1;
  localparam int FW    = DATA_WIDTH + 2;

  logic [CW-1:0]         r_credit;
  logic [MEM_LATENCY:0]  r_vld_pipe;
  tag_t                  r_tag [MEM_LATENCY+1];
  logic                  r_mem_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic                  w_accept, w_pop, w_fifo_valid;
  tag_t                  w_tag, w_tag_out;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [FW-1:0]         w_wdata, w_rdata;

  // Credits count every accepted pixel not yet popped, so the FIFO can always
  // absorb whatever is still in the read pipeline.
  assign s_ready  = !reset && (r_credit < CW'(DEPTH));
  assign w_accept = s_valid && s_ready;
  assign w_pop    = w_fifo_valid && m_ready;
  assign w_addr   = ADDR_WIDTH'(s_y) * ADDR_WIDTH'(SRC_X_NUM) + ADDR_WIDTH'(s_x);

  always_comb begin
    w_tag         = '0;
    w_tag[TAG_FS] = s_frame_start;
    w_tag[TAG_LE] = s_line_end;
    w_tag[TAG_RO] = s_range_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit   <= '0;
      r_vld_pipe <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[MEM_LATENCY-1:0], w_accept};
      r_tag[0]   <= w_tag;
      for (int i = 1; i <= MEM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      r_mem_en   <= w_accept && !s_range_out;
      if (w_accept && !s_range_out) r_mem_addr <= w_addr;
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign w_tag_out = r_tag[MEM_LATENCY];
  assign w_wdata   = {w_tag_out[TAG_FS], w_tag_out[TAG_LE],
                      w_tag_out[TAG_RO] ? BG_COLOR : mem_rdata};

  sample_projective_pixel_fifo #(
    .WIDTH (FW),
    .PTR_W (FIFO_PTR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (r_vld_pipe[MEM_LATENCY]),
    .i_wdata (w_wdata),
    .i_rd    (m_ready),
    .o_rdata (w_rdata),
    .o_valid (w_fifo_valid)
  );

  assign m_valid       = w_fifo_valid;
  assign m_frame_start = w_rdata[FW-1];
  assign m_line_end    = w_rdata[FW-2];
  assign m_data        = w_rdata[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_sample_projective_pixel.sv
// Directed vectors plus scoreboarded streams for the projective pixel sampler.
module tb_sample_projective_pixel;
  localparam int XW = 10, YW = 10, AW = 19, DW = 24, ML = 2, PW = 3;
  localparam logic [DW-1:0] BG = 24'hA5C3E1;

  logic clk, reset;
  logic s_frame_start, s_line_end, s_range_out, s_valid, s_ready;
  logic [XW-1:0] s_x;
  logic [YW-1:0] s_y;
  logic mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic m_frame_start, m_line_end, m_valid, m_ready;
  logic [DW-1:0] m_data;

  sample_projective_pixel #(
    .SRC_X_WIDTH(XW), .SRC_Y_WIDTH(YW), .SRC_X_NUM(640), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .MEM_LATENCY(ML), .FIFO_PTR_WIDTH(PW), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset(reset),
    .s_frame_start(s_frame_start), .s_line_end(s_line_end), .s_range_out(s_range_out),
    .s_x(s_x), .s_y(s_y), .s_valid(s_valid), .s_ready(s_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_frame_start(m_frame_start), .m_line_end(m_line_end), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory model: data = address, ML cycles after the address is presented
  logic [AW-1:0] a_pipe [ML];
  always @(posedge clk) begin
    a_pipe[0] <= mem_addr;
    for (int i = 1; i < ML; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign mem_rdata = {5'b0, a_pipe[ML-1]};

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic ro, fs, le;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
  } vec_t;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic ro, fs, le;
  } pix_t;

  typedef struct {
    logic fs, le;
    logic [DW-1:0] data;
  } exp_t;

  pix_t send_q[$];
  exp_t exp_q[$];
  int   n_acc = 0;

  task automatic push_pix(input int x, input int y, input logic ro, input logic fs, input logic le);
    pix_t p;
    exp_t e;
    int a;
    p.x = XW'(x); p.y = YW'(y); p.ro = ro; p.fs = fs; p.le = le;
    a = y * 640 + x;
    e.fs = fs; e.le = le;
    e.data = ro ? BG : DW'(AW'(a));
    send_q.push_back(p);
    exp_q.push_back(e);
  endtask

  // One cycle of randomised producer/consumer activity with output scoreboarding
  task automatic step(input int pv, input int pr);
    exp_t e;
    m_ready = ($urandom_range(99) < pr);
    if (m_valid && m_ready) begin
      chk("exp_avail", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pix", {m_frame_start, m_line_end, m_data}, {e.fs, e.le, e.data});
      end
    end
    s_valid = (send_q.size() != 0) && ($urandom_range(99) < pv);
    if (s_valid) begin
      s_x = send_q[0].x; s_y = send_q[0].y; s_range_out = send_q[0].ro;
      s_frame_start = send_q[0].fs; s_line_end = send_q[0].le;
      if (s_ready) begin
        void'(send_q.pop_front());
        n_acc++;
      end
    end
    tick();
  endtask

  task automatic drain(input int pv, input int pr, input int budget);
    int c = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
      step(pv, pr);
      c++;
    end
    chk("drain_left", send_q.size() + exp_q.size(), 0);
  endtask

  task automatic frame(input int npix);
    int x;
    logic ro;
    for (int k = 0; k < npix; k++) begin
      ro = ($urandom_range(9) == 0);
      x = ro ? 'h3FF : k % 640;
      push_pix(x, ro ? 'h3FF : k / 640, ro, k == 0, (k % 640) == 639);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int lat, en_cnt, acc0;
    vecs[0] = '{x:3,     y:2,     ro:0, fs:1, le:0, eaddr:1283,   edata:1283};
    vecs[1] = '{x:639,   y:479,   ro:0, fs:0, le:1, eaddr:307199, edata:307199};
    vecs[2] = '{x:'h3FF, y:'h3FF, ro:1, fs:1, le:1, eaddr:0,      edata:BG};
    vecs[3] = '{x:0,     y:0,     ro:0, fs:0, le:0, eaddr:0,      edata:0};
    vecs[4] = '{x:5,     y:1,     ro:1, fs:0, le:1, eaddr:0,      edata:BG};
    vecs[5] = '{x:100,   y:10,    ro:0, fs:1, le:1, eaddr:6500,   edata:6500};

    reset = 1; s_valid = 0; m_ready = 0; s_x = 0; s_y = 0;
    s_frame_start = 0; s_line_end = 0; s_range_out = 0;
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out", {m_frame_start, m_line_end, m_data}, 0);
    tick();
    reset = 0;
    tick();
    chk("post_rst_s_ready", s_ready, 1);

    // Directed single-pixel vectors, m_ready held high
    m_ready = 1;
    for (int v = 0; v < 6; v++) begin
      s_x = vecs[v].x; s_y = vecs[v].y; s_range_out = vecs[v].ro;
      s_frame_start = vecs[v].fs; s_line_end = vecs[v].le; s_valid = 1;
      chk("vec_s_ready", s_ready, 1);
      tick();
      s_valid = 0;
      lat = 1;
      en_cnt = mem_en ? 1 : 0;
      if (!vecs[v].ro) chk("vec_addr", mem_addr, vecs[v].eaddr);
      while (!m_valid && lat < 20) begin
        tick();
        lat++;
        if (mem_en) en_cnt++;
      end
      chk("vec_mem_en_pulses", en_cnt, vecs[v].ro ? 0 : 1);
      chk("vec_latency", lat, ML + 2);
      chk("vec_pix", {m_frame_start, m_line_end, m_data},
          {vecs[v].fs, vecs[v].le, vecs[v].edata});
      tick();
      chk("vec_popped", m_valid, 0);
    end

    // Backpressure: 20 offered with m_ready low, only the FIFO depth gets in
    for (int i = 0; i < 20; i++) push_pix(i, 7, (i % 5) == 3, i == 0, i == 19);
    acc0 = n_acc;
    for (int c = 0; c < 30; c++) step(100, 0);
    chk("bp_accepted", n_acc - acc0, 2**PW);
    chk("bp_s_ready_low", s_ready, 0);
    step(0, 100);
    chk("bp_s_ready_after_pop", s_ready, 1);
    drain(100, 100, 200);

    // Random-handshake stream covering three full lines
    frame(3 * 640);
    drain(70, 70, 20000);
    chk("stream_idle", m_valid, 0);

    // Reset with pixels in flight
    for (int i = 0; i < 5; i++) push_pix(i + 40, 3, 0, i == 0, 0);
    acc0 = n_acc;
    for (int c = 0; c < 20 && (n_acc - acc0) < 5; c++) step(100, 0);
    chk("mid_accepted", n_acc - acc0, 5);
    reset = 1; s_valid = 0; m_ready = 1;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    reset = 0;
    send_q.delete();
    exp_q.delete();
    for (int c = 0; c < 12; c++) step(0, 100);
    chk("no_stale", m_valid, 0);
    frame(700);
    drain(80, 80, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
